// File: rtl/e_mdu.sv
// ---------------------------------------------------------------------------
// e_mdu -- multiply/divide unit with architectural HI/LO registers.
//
// Accepts one-cycle start requests. MULT/MULTU and DIV/DIVU hold busy for a
// fixed number of cycles and write HI/LO on the completing edge. MTHI/MTLO
// write a single register in the same cycle. Requests that arrive while busy
// are ignored.
//
// Parameters:
//   MULT_CYCLES  busy duration of MULT/MULTU (1..15)
//   DIV_CYCLES   busy duration of DIV/DIVU   (1..15)
//
// Ports:
//   clk    in   1   clock, rising edge
//   reset  in   1   asynchronous reset, active low
//   start  in   1   one-cycle request to execute MDUOp on A/B
//   MDUOp  in   3   0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NOP
//   A      in  32   operand 1 (dividend / multiplicand / MTHI-MTLO source)
//   B      in  32   operand 2 (divisor / multiplier)
//   busy   out  1   registered, high while a MULT/DIV is in flight
//   HI     out 32   HI register
//   LO     out 32   LO register
// ---------------------------------------------------------------------------
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    state_t      state;
    logic [3:0]  count;
    op_t         op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] mag_q;
    logic [31:0] mag_r;
    logic [31:0] sdiv_q;
    logic [31:0] sdiv_r;
    logic [31:0] udiv_q;
    logic [31:0] udiv_r;

    // Result datapath works on the latched operands only, so changes on A/B
    // during RUN cannot reach HI/LO.
    // The signed product is taken as a 64-bit modular product of the
    // sign-extended operands, which equals the two's-complement product.
    // Signed division goes through magnitudes so that 0x80000000 / -1 simply
    // wraps to 0x80000000 instead of hitting an overflow corner.
    always_comb begin
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u = {32'd0, a_q} * {32'd0, b_q};

        neg_a = a_q[31];
        neg_b = b_q[31];
        abs_a = neg_a ? (~a_q + 32'd1) : a_q;
        abs_b = neg_b ? (~b_q + 32'd1) : b_q;

        if (b_q == 32'd0) begin
            mag_q  = 32'd0;
            mag_r  = 32'd0;
            udiv_q = 32'd0;
            udiv_r = 32'd0;
        end else begin
            mag_q  = abs_a / abs_b;
            mag_r  = abs_a % abs_b;
            udiv_q = a_q / b_q;
            udiv_r = a_q % b_q;
        end

        sdiv_q = (neg_a ^ neg_b) ? (~mag_q + 32'd1) : mag_q;
        sdiv_r = neg_a ? (~mag_r + 32'd1) : mag_r;
    end

    // Control FSM, operand latches and HI/LO. Starts are only honoured in
    // IDLE; in RUN the counter runs down and the edge that sees count==1
    // commits the result (skipped for a zero divisor) and returns to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= 4'd0;
            busy  <= 1'b0;
            op_q  <= OP_NOP;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op_t'(MDUOp))
                            OP_MULT, OP_MULTU: begin
                                op_q  <= op_t'(MDUOp);
                                a_q   <= A;
                                b_q   <= B;
                                count <= MULT_LOAD;
                                busy  <= 1'b1;
                                state <= RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                op_q  <= op_t'(MDUOp);
                                a_q   <= A;
                                b_q   <= B;
                                count <= DIV_LOAD;
                                busy  <= 1'b1;
                                state <= RUN;
                            end
                            OP_MTHI: HI <= A;
                            OP_MTLO: LO <= A;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                        case (op_q)
                            OP_MULT: begin
                                HI <= prod_s[63:32];
                                LO <= prod_s[31:0];
                            end
                            OP_MULTU: begin
                                HI <= prod_u[63:32];
                                LO <= prod_u[31:0];
                            end
                            OP_DIV: begin
                                if (b_q != 32'd0) begin
                                    HI <= sdiv_r;
                                    LO <= sdiv_q;
                                end
                            end
                            OP_DIVU: begin
                                if (b_q != 32'd0) begin
                                    HI <= udiv_r;
                                    LO <= udiv_q;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// ---------------------------------------------------------------------------
// tb_e_mdu -- self-checking bench for e_mdu.
//
// Directed vectors plus randomized operations checked against an arithmetic
// reference model (64-bit integer multiply/divide). Inputs are driven just
// after falling edges and outputs are sampled on falling edges.
// ---------------------------------------------------------------------------
module tb_e_mdu;

    localparam int MULT_N  = 5;
    localparam int DIV_N   = 10;
    localparam int TIMEOUT = 40;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int total;
    int bad;

    logic [31:0] hi_m;
    logic [31:0] lo_m;

    e_mdu #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .MDUOp(MDUOp),
        .A    (A),
        .B    (B),
        .busy (busy),
        .HI   (HI),
        .LO   (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    // Reference model: architectural effect of one accepted operation.
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ps, q, r;
        longint unsigned ua, ub, pu, uq, ur;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        case (op)
            3'd1: begin ps = sa * sb; hi_m = ps[63:32]; lo_m = ps[31:0]; end
            3'd2: begin pu = ua * ub; hi_m = pu[63:32]; lo_m = pu[31:0]; end
            3'd3: if (b != 32'd0) begin
                q = sa / sb; r = sa % sb; lo_m = q[31:0]; hi_m = r[31:0];
            end
            3'd4: if (b != 32'd0) begin
                uq = ua / ub; ur = ua % ub; lo_m = uq[31:0]; hi_m = ur[31:0];
            end
            3'd5: hi_m = a;
            3'd6: lo_m = a;
            default: ;
        endcase
    endtask

    function automatic int exp_busy(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return MULT_N;
        if (op == 3'd3 || op == 3'd4) return DIV_N;
        return 0;
    endfunction

    // Stimulus only: issue one start (caller is just past a falling edge),
    // scramble A/B while busy, count busy cycles and note whether HI/LO ever
    // left their pre-operation model values while busy.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int cycles, output bit held);
        cycles = 0;
        held   = 1'b1;
        start  = 1'b1;
        MDUOp  = op;
        A      = a;
        B      = b;
        @(negedge clk);
        start = 1'b0;
        MDUOp = 3'($urandom);
        while (busy === 1'b1 && cycles < TIMEOUT) begin
            if (HI !== hi_m || LO !== lo_m) held = 1'b0;
            cycles++;
            A = $urandom;
            B = $urandom;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        MDUOp = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++;
        if (HI !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=00000000", HI); end
        total++;
        if (LO !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=00000000", LO); end
        reset = 1'b1;
        hi_m  = 32'd0;
        lo_m  = 32'd0;
    endtask

    task automatic test_directed();
        vec_t v[8];
        int   cyc;
        bit   held;
        v[0] = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
        v[1] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        v[2] = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        v[3] = '{3'd5, 32'h00000011, 32'h0,        32'h00000011, 32'hFFFFFFFD};
        v[4] = '{3'd6, 32'h00000022, 32'h0,        32'h00000011, 32'h00000022};
        v[5] = '{3'd4, 32'd7,        32'd0,        32'h00000011, 32'h00000022};
        v[6] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        v[7] = '{3'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        foreach (v[i]) begin
            do_op(v[i].op, v[i].a, v[i].b, cyc, held);
            model_op(v[i].op, v[i].a, v[i].b);
            total++;
            if (cyc !== exp_busy(v[i].op)) begin
                bad++; $display("FAIL dir%0d_busy cycles got=%0d want=%0d", i, cyc, exp_busy(v[i].op));
            end
            total++;
            if (!held) begin bad++; $display("FAIL dir%0d_hold HI/LO changed while busy", i); end
            total++;
            if (HI !== v[i].hi) begin bad++; $display("FAIL dir%0d_hi got=%h want=%h", i, HI, v[i].hi); end
            total++;
            if (LO !== v[i].lo) begin bad++; $display("FAIL dir%0d_lo got=%h want=%h", i, LO, v[i].lo); end
        end
    endtask

    task automatic test_mt_consecutive();
        bit saw_busy;
        saw_busy = 1'b0;
        start = 1'b1;
        MDUOp = 3'd5;
        A     = 32'h1234;
        @(negedge clk);
        if (busy !== 1'b0) saw_busy = 1'b1;
        MDUOp = 3'd6;
        A     = 32'h5678;
        @(negedge clk);
        if (busy !== 1'b0) saw_busy = 1'b1;
        start = 1'b0;
        hi_m  = 32'h1234;
        lo_m  = 32'h5678;
        total++;
        if (saw_busy) begin bad++; $display("FAIL mt_busy got=1 want=0"); end
        total++;
        if (HI !== 32'h1234) begin bad++; $display("FAIL mt_hi got=%h want=00001234", HI); end
        total++;
        if (LO !== 32'h5678) begin bad++; $display("FAIL mt_lo got=%h want=00005678", LO); end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] a, b;
        int          n;
        a = $urandom;
        b = $urandom;
        start = 1'b1;
        MDUOp = 3'd1;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        n     = 1;
        @(negedge clk);
        n++;
        start = 1'b1;
        MDUOp = 3'd5;
        A     = 32'hDEAD;
        @(negedge clk);
        start = 1'b0;
        if (busy === 1'b1) n++;
        while (busy === 1'b1 && n < TIMEOUT) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
        end
        model_op(3'd1, a, b);
        total++;
        if (n !== MULT_N) begin bad++; $display("FAIL ignore_busy cycles got=%0d want=%0d", n, MULT_N); end
        total++;
        if (HI !== hi_m) begin bad++; $display("FAIL ignore_hi got=%h want=%h", HI, hi_m); end
        total++;
        if (LO !== lo_m) begin bad++; $display("FAIL ignore_lo got=%h want=%h", LO, lo_m); end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        int          cyc;
        bit          held;
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 50));
            do_op(op, a, b, cyc, held);
            model_op(op, a, b);
            total++;
            if (cyc !== exp_busy(op)) begin
                bad++; $display("FAIL rand%0d_busy op=%0d cycles got=%0d want=%0d", i, op, cyc, exp_busy(op));
            end
            total++;
            if (!held) begin bad++; $display("FAIL rand%0d_hold op=%0d HI/LO changed while busy", i, op); end
            total++;
            if (HI !== hi_m || LO !== lo_m) begin
                bad++;
                $display("FAIL rand%0d_result op=%0d a=%h b=%h got=%h_%h want=%h_%h",
                         i, op, a, b, HI, LO, hi_m, lo_m);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops[3];
        logic [31:0] a, b;
        int          cyc;
        bit          held;
        ops[0] = 3'd2;
        ops[1] = 3'd3;
        ops[2] = 3'd1;
        foreach (ops[i]) begin
            a = $urandom;
            b = $urandom | 32'd1;
            do_op(ops[i], a, b, cyc, held);
            model_op(ops[i], a, b);
            total++;
            if (cyc !== exp_busy(ops[i]) || HI !== hi_m || LO !== lo_m) begin
                bad++;
                $display("FAIL b2b%0d cycles=%0d hi=%h lo=%h want cycles=%0d hi=%h lo=%h",
                         i, cyc, HI, LO, exp_busy(ops[i]), hi_m, lo_m);
            end
        end
    endtask

    task automatic test_idle_hold();
        int cyc;
        bit held;
        do_op(3'd0, $urandom, $urandom, cyc, held);
        do_op(3'd7, $urandom, $urandom, cyc, held);
        repeat (5) @(negedge clk);
        total++;
        if (busy !== 1'b0 || HI !== hi_m || LO !== lo_m) begin
            bad++;
            $display("FAIL idle_hold busy=%b hi=%h lo=%h want busy=0 hi=%h lo=%h", busy, HI, LO, hi_m, lo_m);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        bit held;
        do_op(3'd5, 32'hAAAA5555, 32'd0, cyc, held);
        do_op(3'd6, 32'h5555AAAA, 32'd0, cyc, held);
        model_op(3'd5, 32'hAAAA5555, 32'd0);
        model_op(3'd6, 32'h5555AAAA, 32'd0);
        start = 1'b1;
        MDUOp = 3'd3;
        A     = 32'd1000;
        B     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            bad++;
            $display("FAIL async_reset busy=%b hi=%h lo=%h want 0/0/0", busy, HI, LO);
        end
        @(negedge clk);
        reset = 1'b1;
        hi_m  = 32'd0;
        lo_m  = 32'd0;
        repeat (DIV_N + 2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            bad++;
            $display("FAIL reset_abort busy=%b hi=%h lo=%h want 0/0/0", busy, HI, LO);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_directed();
        test_mt_consecutive();
        test_busy_ignore();
        test_random();
        test_back_to_back();
        test_idle_hold();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
